irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Edge-triggered interrupt controller for N level-signal sources. Each channel runs its own edge detector with per-channel polarity select, latches detected edges into a pending register, and reports overruns. A fixed-priority arbiter picks one enabled pending channel and presents it to a single requester (CPU or sequencer) through an irq/ack handshake. It sits between raw status/level signals from peripherals and the core's interrupt input.

## Interface

Parameters:
- N, 8, number of interrupt sources (1..32)
- ID_W, 3, width of irq_id; must satisfy 2^ID_W >= N

Ports:
- clk  in  1  single clock; all logic on posedge
- resetn  in  1  asynchronous, active-low reset
- src  in  N  level inputs; synchronous to clk (synchronized upstream)
- pol  in  N  per-channel edge select: 1 = rising, 0 = falling
- mask  in  N  per-channel enable: 1 = eligible for arbitration
- clr_all  in  1  synchronous clear of pending, overrun and any active request
- irq_ack  in  1  requester acknowledge; one-cycle pulse
- irq  out  1  interrupt request, registered
- irq_id  out  ID_W  index of granted channel, valid while irq = 1
- pending  out  N  pending register, registered
- overrun  out  N  sticky: edge arrived while channel already pending

## Operation

- Per channel i: s_r[i] <= src[i] each cycle, reset 0. edge[i] = pol[i] ? (src[i] & ~s_r[i]) : (~src[i] & s_r[i]). Combinational; pol changes may themselves produce an edge, which is accepted.
- Pending update, priority highest first: clr_all -> 0; edge[i] -> 1; ack-clear of granted channel -> 0; else hold. Edge on the granted channel in the ack cycle re-pends it (set wins over ack-clear). clr_all wins over same-cycle edges.
- Pending latched regardless of mask; mask gates arbitration only.
- overrun[i] <= 1 when edge[i] & pending[i] & ~(ack-clear of i this cycle). Cleared only by clr_all or reset.
- FSM, two states:
  - IDLE: if (pending & mask) != 0 and not clr_all, go to REQ; irq <= 1; irq_id <= lowest set index of (pending & mask).
  - REQ: irq held 1, irq_id frozen. On irq_ack: clear pending[irq_id], irq <= 0, go to IDLE. On clr_all: irq <= 0, go to IDLE; clr_all dominates a simultaneous ack.
- Grant is committed: a mask drop or higher-priority arrival during REQ does not change irq_id or withdraw irq.
- irq_ack in IDLE is ignored, with no state change.
- Reset: s_r = 0, pending = 0, overrun = 0, irq = 0, irq_id = 0, state = IDLE. Reset is asynchronous, so reset mid-request drops irq immediately.
- Reset value s_r = 0: a src held high through reset produces a rising edge on the first cycle after release.

## Timing

- src transitions before edge k: pending[i] = 1 after edge k; irq = 1 and irq_id valid after edge k+1. Edge-to-irq latency is 2 clocks.
- irq_ack sampled at edge a: irq = 0 and pending[irq_id] = 0 after edge a.
- Next grant: irq = 1 after edge a+1 at the earliest, so irq is low for at least 1 cycle between grants.
- pending and overrun are visible 1 clock after the causing edge.
- No combinational path from any input to any output.

## Test plan

- Single rising edge: N=8, pol=0xFF, mask=0xFF; src[3] 0->1 before edge 10 -> pending=0x08 after edge 10; irq=1, irq_id=3 after edge 11; ack at edge 14 -> irq=0 and pending=0x00 after edge 14.
- Priority and commit: edges on ch5 and ch2 in the same cycle -> irq_id=2. Then ch0 edge during REQ -> irq_id stays 2. After ack, irq low 1 cycle, then irq_id=0, then 5 after its own ack.
- Polarity and mask: pol[1]=0, mask[1]=0, src[1] 1->0 -> pending[1]=1, irq stays 0. Set mask[1]=1 -> irq=1, irq_id=1 two edges later.
- Overrun and re-pend: second ch4 edge while pending[4]=1 -> overrun=0x10. Ch4 edge coinciding with ack of ch4 -> pending[4] stays 1, overrun[4] not newly set, regrant of ch4.
- clr_all: during REQ with pending=0x81 and overrun=0x01, assert clr_all together with irq_ack -> irq=0, pending=0, overrun=0 next cycle, no regrant.
- Reset mid-request: assert resetn=0 asynchronously while irq=1 -> irq, pending and irq_id go to 0 without a clock. With src[0] held high across release and pol[0]=1 -> pending[0]=1 after the first edge post-release.

Source files
------------

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: per-channel edge detect with polarity select,
// sticky pending/overrun latches, fixed-priority grant held through an irq/ack handshake.
module irq_ctrl #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N-1:0]    src,
  input  logic [N-1:0]    pol,
  input  logic [N-1:0]    mask,
  input  logic            clr_all,
  input  logic            irq_ack,
  output logic            irq,
  output logic [ID_W-1:0] irq_id,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overrun
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t          state_q;
  logic            irq_q;
  logic [ID_W-1:0] irq_id_q;
  logic [N-1:0]    src_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    overrun_q, overrun_d;
  logic [N-1:0]    edge_det;
  logic [N-1:0]    ack_clr;
  logic [N-1:0]    req;
  logic [ID_W-1:0] grant_id;
  logic            ack_go;

  // A clr_all in the ack cycle takes over the whole clear, so the ack itself is dropped.
  assign ack_go = (state_q == S_REQ) && irq_ack && !clr_all;
  assign req    = pending_q & mask;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign edge_det[gi] = pol[gi] ? (src[gi] & ~src_q[gi]) : (~src[gi] & src_q[gi]);
    assign ack_clr[gi]  = ack_go && (irq_id_q == ID_W'(gi));
  end

  always_comb begin
    grant_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) grant_id = ID_W'(i);
    end
  end

  // Set beats ack-clear so an edge landing in the ack cycle re-pends the channel.
  always_comb begin
    if (clr_all) begin
      pending_d = '0;
      overrun_d = '0;
    end else begin
      pending_d = (pending_q & ~ack_clr) | edge_det;
      overrun_d = overrun_q | (edge_det & pending_q & ~ack_clr);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_q     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      src_q     <= src;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if ((req != '0) && !clr_all) begin
            state_q  <= S_REQ;
            irq_q    <= 1'b1;
            irq_id_q <= grant_id;
          end
        end
        S_REQ: begin
          if (clr_all || irq_ack) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq     = irq_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scenario-driven bench for irq_ctrl: each task runs a per-cycle table of stimulus and
// hand-derived expected outputs through a scoreboard queue.
module tb_irq_ctrl;

  localparam int N    = 8;
  localparam int ID_W = 3;

  // Observation vector layout: {irq, irq_id[2:0], pending[7:0], overrun[7:0]}
  localparam logic [19:0] M_ALL  = 20'hFFFFF;
  localparam logic [19:0] M_NOID = 20'h8FFFF;
  localparam logic [19:0] M_PEND = 20'h0FF00;

  typedef struct packed {
    logic [7:0]  src;
    logic [7:0]  pol;
    logic [7:0]  mask;
    logic        clr;
    logic        ack;
    logic [19:0] exp;
    logic [19:0] m;
  } cyc_t;

  logic            clk;
  logic            resetn;
  logic [N-1:0]    src, pol, mask;
  logic            clr_all, irq_ack;
  logic            irq;
  logic [ID_W-1:0] irq_id;
  logic [N-1:0]    pending, overrun;
  logic [19:0]     obs;

  int   n_checks = 0;
  int   n_fail   = 0;
  cyc_t sbq[$];

  irq_ctrl #(.N(N), .ID_W(ID_W)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .src     (src),
    .pol     (pol),
    .mask    (mask),
    .clr_all (clr_all),
    .irq_ack (irq_ack),
    .irq     (irq),
    .irq_id  (irq_id),
    .pending (pending),
    .overrun (overrun)
  );

  assign obs = {irq, irq_id, pending, overrun};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic cyc_t c(input logic [7:0] s, input logic [7:0] p, input logic [7:0] mk,
                             input logic cl, input logic ak, input logic ir,
                             input logic [2:0] id, input logic [7:0] pe, input logic [7:0] ov,
                             input logic [19:0] m);
    cyc_t r;
    r.src  = s;
    r.pol  = p;
    r.mask = mk;
    r.clr  = cl;
    r.ack  = ak;
    r.exp  = {ir, id, pe, ov};
    r.m    = m;
    return r;
  endfunction

  task automatic drive(input cyc_t x);
    src     = x.src;
    pol     = x.pol;
    mask    = x.mask;
    clr_all = x.clr;
    irq_ack = x.ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc_t e;
    resetn = 1'b1;
    drive(c(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, M_ALL));
    #2 resetn = 1'b0;
    sbq.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, M_ALL));
    #1;
    e = sbq.pop_front();
    n_checks++;
    if ((obs & e.m) !== (e.exp & e.m)) begin
      n_fail++;
      $display("FAIL reset_async: got %h required %h", obs & e.m, e.exp & e.m);
    end
    $display("reset_async: irq=%b id=%0d pend=%h ovr=%h", irq, irq_id, pending, overrun);
    step();
    step();
    resetn = 1'b1;
    sbq.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, M_ALL));
    step();
    e = sbq.pop_front();
    n_checks++;
    if ((obs & e.m) !== (e.exp & e.m)) begin
      n_fail++;
      $display("FAIL reset_idle: got %h required %h", obs & e.m, e.exp & e.m);
    end
    $display("reset_idle: irq=%b id=%0d pend=%h ovr=%h", irq, irq_id, pending, overrun);
  endtask

  task automatic test_single();
    cyc_t t[$];
    cyc_t e;
    t.push_back(c(8'h08, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h08, 8'h00, M_NOID));
    t.push_back(c(8'h08, 8'hFF, 8'hFF, 0, 0, 1, 3, 8'h08, 8'h00, M_ALL));
    t.push_back(c(8'h08, 8'hFF, 8'hFF, 0, 0, 1, 3, 8'h08, 8'h00, M_ALL));
    t.push_back(c(8'h08, 8'hFF, 8'hFF, 0, 0, 1, 3, 8'h08, 8'h00, M_ALL));
    t.push_back(c(8'h08, 8'hFF, 8'hFF, 0, 1, 0, 0, 8'h00, 8'h00, M_NOID));
    t.push_back(c(8'h08, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, M_NOID));
    t.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 8'h00, 8'h00, M_NOID));
    t.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, M_NOID));
    foreach (t[k]) begin
      drive(t[k]);
      sbq.push_back(t[k]);
      step();
      e = sbq.pop_front();
      n_checks++;
      if ((obs & e.m) !== (e.exp & e.m)) begin
        n_fail++;
        $display("FAIL single[%0d]: got %h required %h", k, obs & e.m, e.exp & e.m);
      end
      $display("single[%0d]: irq=%b id=%0d pend=%h ovr=%h", k, irq, irq_id, pending, overrun);
    end
  endtask

  task automatic test_priority();
    cyc_t t[$];
    cyc_t e;
    t.push_back(c(8'h24, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h24, 8'h00, M_NOID));
    t.push_back(c(8'h24, 8'hFF, 8'hFF, 0, 0, 1, 2, 8'h24, 8'h00, M_ALL));
    t.push_back(c(8'h25, 8'hFF, 8'hFF, 0, 0, 1, 2, 8'h25, 8'h00, M_ALL));
    t.push_back(c(8'h25, 8'hFF, 8'hFF, 0, 0, 1, 2, 8'h25, 8'h00, M_ALL));
    t.push_back(c(8'h25, 8'hFF, 8'hFF, 0, 1, 0, 0, 8'h21, 8'h00, M_NOID));
    t.push_back(c(8'h25, 8'hFF, 8'hFF, 0, 0, 1, 0, 8'h21, 8'h00, M_ALL));
    t.push_back(c(8'h25, 8'hFF, 8'hFF, 0, 1, 0, 0, 8'h20, 8'h00, M_NOID));
    t.push_back(c(8'h25, 8'hFF, 8'hFF, 0, 0, 1, 5, 8'h20, 8'h00, M_ALL));
    t.push_back(c(8'h25, 8'hFF, 8'hFF, 0, 1, 0, 0, 8'h00, 8'h00, M_NOID));
    t.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, M_NOID));
    foreach (t[k]) begin
      drive(t[k]);
      sbq.push_back(t[k]);
      step();
      e = sbq.pop_front();
      n_checks++;
      if ((obs & e.m) !== (e.exp & e.m)) begin
        n_fail++;
        $display("FAIL priority[%0d]: got %h required %h", k, obs & e.m, e.exp & e.m);
      end
      $display("priority[%0d]: irq=%b id=%0d pend=%h ovr=%h", k, irq, irq_id, pending, overrun);
    end
  endtask

  task automatic test_pol_mask();
    cyc_t t[$];
    cyc_t e;
    t.push_back(c(8'h02, 8'hFD, 8'hFD, 0, 0, 0, 0, 8'h00, 8'h00, M_NOID));
    t.push_back(c(8'h00, 8'hFD, 8'hFD, 0, 0, 0, 0, 8'h02, 8'h00, M_NOID));
    t.push_back(c(8'h00, 8'hFD, 8'hFD, 0, 0, 0, 0, 8'h02, 8'h00, M_NOID));
    t.push_back(c(8'h00, 8'hFD, 8'hFF, 0, 0, 0, 0, 8'h02, 8'h00, M_PEND));
    t.push_back(c(8'h00, 8'hFD, 8'hFF, 0, 0, 1, 1, 8'h02, 8'h00, M_ALL));
    t.push_back(c(8'h00, 8'hFD, 8'hFF, 0, 1, 0, 0, 8'h00, 8'h00, M_NOID));
    t.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, M_NOID));
    foreach (t[k]) begin
      drive(t[k]);
      sbq.push_back(t[k]);
      step();
      e = sbq.pop_front();
      n_checks++;
      if ((obs & e.m) !== (e.exp & e.m)) begin
        n_fail++;
        $display("FAIL pol_mask[%0d]: got %h required %h", k, obs & e.m, e.exp & e.m);
      end
      $display("pol_mask[%0d]: irq=%b id=%0d pend=%h ovr=%h", k, irq, irq_id, pending, overrun);
    end
  endtask

  task automatic test_overrun_repend();
    cyc_t t[$];
    cyc_t e;
    t.push_back(c(8'h10, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h10, 8'h00, M_NOID));
    t.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 0, 1, 4, 8'h10, 8'h00, M_ALL));
    t.push_back(c(8'h10, 8'hFF, 8'hFF, 0, 1, 0, 0, 8'h10, 8'h00, M_NOID));
    t.push_back(c(8'h10, 8'hFF, 8'hFF, 0, 0, 1, 4, 8'h10, 8'h00, M_ALL));
    t.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 0, 1, 4, 8'h10, 8'h00, M_ALL));
    t.push_back(c(8'h10, 8'hFF, 8'hFF, 0, 0, 1, 4, 8'h10, 8'h10, M_ALL));
    t.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 8'h00, 8'h10, M_NOID));
    t.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h10, M_NOID));
    foreach (t[k]) begin
      drive(t[k]);
      sbq.push_back(t[k]);
      step();
      e = sbq.pop_front();
      n_checks++;
      if ((obs & e.m) !== (e.exp & e.m)) begin
        n_fail++;
        $display("FAIL overrun[%0d]: got %h required %h", k, obs & e.m, e.exp & e.m);
      end
      $display("overrun[%0d]: irq=%b id=%0d pend=%h ovr=%h", k, irq, irq_id, pending, overrun);
    end
  endtask

  task automatic test_clr_all();
    cyc_t t[$];
    cyc_t e;
    t.push_back(c(8'h00, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, M_NOID));
    t.push_back(c(8'h81, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h81, 8'h00, M_NOID));
    t.push_back(c(8'h80, 8'hFF, 8'hFF, 0, 0, 1, 0, 8'h81, 8'h00, M_ALL));
    t.push_back(c(8'h81, 8'hFF, 8'hFF, 0, 0, 1, 0, 8'h81, 8'h01, M_ALL));
    t.push_back(c(8'h81, 8'hFF, 8'hFF, 1, 1, 0, 0, 8'h00, 8'h00, M_NOID));
    t.push_back(c(8'h81, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, M_NOID));
    t.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, M_NOID));
    t.push_back(c(8'h02, 8'hFF, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, M_NOID));
    t.push_back(c(8'h02, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, M_NOID));
    t.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, M_NOID));
    foreach (t[k]) begin
      drive(t[k]);
      sbq.push_back(t[k]);
      step();
      e = sbq.pop_front();
      n_checks++;
      if ((obs & e.m) !== (e.exp & e.m)) begin
        n_fail++;
        $display("FAIL clr_all[%0d]: got %h required %h", k, obs & e.m, e.exp & e.m);
      end
      $display("clr_all[%0d]: irq=%b id=%0d pend=%h ovr=%h", k, irq, irq_id, pending, overrun);
    end
  endtask

  task automatic test_reset_mid();
    cyc_t t[$];
    cyc_t u[$];
    cyc_t e;
    t.push_back(c(8'h01, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h01, 8'h00, M_NOID));
    t.push_back(c(8'h01, 8'hFF, 8'hFF, 0, 0, 1, 0, 8'h01, 8'h00, M_ALL));
    foreach (t[k]) begin
      drive(t[k]);
      sbq.push_back(t[k]);
      step();
      e = sbq.pop_front();
      n_checks++;
      if ((obs & e.m) !== (e.exp & e.m)) begin
        n_fail++;
        $display("FAIL reset_mid_pre[%0d]: got %h required %h", k, obs & e.m, e.exp & e.m);
      end
      $display("reset_mid_pre[%0d]: irq=%b id=%0d pend=%h ovr=%h", k, irq, irq_id, pending, overrun);
    end
    // Mid-cycle, no clock edge between assertion and the check.
    resetn = 1'b0;
    sbq.push_back(c(8'h01, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, M_ALL));
    #1;
    e = sbq.pop_front();
    n_checks++;
    if ((obs & e.m) !== (e.exp & e.m)) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h required %h", obs & e.m, e.exp & e.m);
    end
    $display("reset_mid_async: irq=%b id=%0d pend=%h ovr=%h", irq, irq_id, pending, overrun);
    #1 resetn = 1'b1;
    u.push_back(c(8'h01, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h01, 8'h00, M_NOID));
    u.push_back(c(8'h01, 8'hFF, 8'hFF, 0, 0, 1, 0, 8'h01, 8'h00, M_ALL));
    u.push_back(c(8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 8'h00, 8'h00, M_NOID));
    foreach (u[k]) begin
      drive(u[k]);
      sbq.push_back(u[k]);
      step();
      e = sbq.pop_front();
      n_checks++;
      if ((obs & e.m) !== (e.exp & e.m)) begin
        n_fail++;
        $display("FAIL reset_mid_post[%0d]: got %h required %h", k, obs & e.m, e.exp & e.m);
      end
      $display("reset_mid_post[%0d]: irq=%b id=%0d pend=%h ovr=%h", k, irq, irq_id, pending, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_pol_mask();
    test_overrun_repend();
    test_clr_all();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
